// File: rtl/div_unit_pkg.sv
// Shared constants, FSM state type and helpers for the iterative divider.
package div_unit_pkg;

  localparam int unsigned DIV_W     = 32;
  localparam int unsigned DIV_CNT_W = 6;
  localparam int unsigned DIV_ITER  = 32;

  localparam logic [DIV_W-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } div_state_e;

  // Two's complement negate when neg is set; used both to form magnitudes and to restore signs.
  function automatic logic [DIV_W-1:0] cond_neg(input logic [DIV_W-1:0] v, input logic neg);
    return neg ? (DIV_W'(0) - v) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract, restore.
module div_step
  import div_unit_pkg::*;
(
  input  logic [DIV_W:0]   rem_i,
  input  logic             bit_i,
  input  logic [DIV_W-1:0] divisor_i,
  output logic [DIV_W:0]   rem_o,
  output logic             q_bit_o
);

  logic [DIV_W:0] shifted;
  logic [DIV_W:0] trial;

  always_comb begin
    shifted = {rem_i[DIV_W-1:0], bit_i};
    trial   = shifted - {1'b0, divisor_i};
    // Partial remainder stays below the divisor, so the MSB of the trial is a clean borrow flag.
    q_bit_o = ~trial[DIV_W];
    rem_o   = q_bit_o ? trial : shifted;
  end

endmodule

// File: rtl/div_unit.sv
// 32-bit signed/unsigned restoring divider, one quotient bit per cycle, MIPS DIV/DIVU semantics.
module div_unit
  import div_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             div_by_zero
);

  div_state_e           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W:0]       rem_q, rem_d;
  logic [DIV_W-1:0]     quo_q, quo_d;
  logic [DIV_W-1:0]     dvsr_q, dvsr_d;
  logic                 sign_a_q, sign_a_d;
  logic                 sign_b_q, sign_b_d;
  logic                 signed_q, signed_d;
  logic                 dz_q, dz_d;
  logic [DIV_W-1:0]     quotient_q, quotient_d;
  logic [DIV_W-1:0]     remainder_q, remainder_d;
  logic                 dz_out_q, dz_out_d;

  logic [DIV_W:0]       step_rem;
  logic                 step_bit;
  logic                 neg_quo;
  logic                 neg_rem;

  div_step u_div_step (
    .rem_i     (rem_q),
    .bit_i     (quo_q[DIV_W-1]),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_bit)
  );

  // Quotient negative when operand signs differ; remainder follows the dividend.
  assign neg_quo = signed_q & (sign_a_q ^ sign_b_q);
  assign neg_rem = signed_q & sign_a_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    signed_d    = signed_q;
    dz_d        = dz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dz_out_d    = dz_out_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StRun;
          cnt_d    = '0;
          rem_d    = '0;
          quo_d    = cond_neg(dividend, is_signed & dividend[DIV_W-1]);
          dvsr_d   = cond_neg(divisor, is_signed & divisor[DIV_W-1]);
          sign_a_d = dividend[DIV_W-1];
          sign_b_d = divisor[DIV_W-1];
          signed_d = is_signed;
          dz_d     = (divisor == '0);
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (cnt_q == DIV_CNT_W'(DIV_ITER)) begin
          state_d = StDone;
          // A zero divisor leaves the dividend magnitude in the remainder; re-signing restores it.
          quotient_d  = dz_q ? DIV_ZERO_Q : cond_neg(quo_q, neg_quo);
          remainder_d = cond_neg(rem_q[DIV_W-1:0], neg_rem);
          dz_out_d    = dz_q;
        end else begin
          rem_d = step_rem;
          quo_d = {quo_q[DIV_W-2:0], step_bit};
          cnt_d = cnt_q + DIV_CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      signed_q    <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dz_out_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      signed_q    <= signed_d;
      dz_q        <= dz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dz_out_q    <= dz_out_d;
    end
  end

  assign busy        = (state_q == StRun);
  assign done        = (state_q == StDone);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dz_out_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, corner sequences, random vs. model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  div_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Plain-arithmetic reference with MIPS rules; 64-bit math sidesteps the INT_MIN / -1 overflow.
  task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa, sb;
    dz = (b == 32'd0);
    if (dz) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Drives a request on a falling edge; returns 1 time unit after the accepting edge.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start     = 1'b1;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1;
    start     = 1'b0;
    is_signed = 1'($urandom);
    dividend  = $urandom;
    divisor   = $urandom;
  endtask

  // Counts edges after the accept until done; optionally fires a stray start at edge inj_at.
  task automatic wait_done(input int inj_at, input logic [31:0] inj_a, input logic [31:0] inj_b,
                           output int lat, output int bcnt);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) bcnt++;
      if (inj_at != 0 && lat == inj_at - 1) begin
        start     = 1'b1;
        is_signed = 1'b1;
        dividend  = inj_a;
        divisor   = inj_b;
      end
      if (inj_at != 0 && lat == inj_at) start = 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag, input logic full);
    int lat, bcnt;
    issue(v.s, v.a, v.b);
    wait_done(0, 32'd0, 32'd0, lat, bcnt);
    check({tag, " quotient"}, quotient, v.q);
    check({tag, " remainder"}, remainder, v.r);
    check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(v.dz));
    if (full) begin
      check({tag, " latency"}, 32'(lat), 32'd33);
      check({tag, " busy cycles"}, 32'(bcnt), 32'd33);
      @(posedge clk);
      #1;
      check({tag, " done pulse width"}, 32'(done), 32'd0);
      check({tag, " quotient held"}, quotient, v.q);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    vec_t rv;
    int   lat, bcnt;
    logic done_seen;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'h0000_0002,  32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    vecs[2] = '{1'b1, 32'h0000_0007,  32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'h0000_0001,  1'b0};
    vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'h0000_0000,  1'b0};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'h0000_0001,  32'hFFFF_FFFF,  32'h0000_0000,  1'b0};
    vecs[5] = '{1'b1, 32'hFFFF_FFFB,  32'h0000_0000,  32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1};
    vecs[6] = '{1'b0, 32'h1234_5678,  32'h0000_0000,  32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
    vecs[7] = '{1'b0, 32'h0000_0005,  32'h8000_0000,  32'h0000_0000,  32'h0000_0005,  1'b0};

    rst       = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset quotient", quotient, 32'd0);
    check("reset remainder", remainder, 32'd0);
    check("reset div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i), 1'b1);
      repeat (2) @(negedge clk);
    end

    // Stray start mid-run is ignored; start in the done cycle chains with no idle gap.
    issue(1'b0, 32'd100, 32'd7);
    wait_done(10, 32'd50, 32'd5, lat, bcnt);
    check("midrun quotient", quotient, 32'd14);
    check("midrun remainder", remainder, 32'd2);
    check("midrun latency", 32'(lat), 32'd33);
    issue(1'b0, 32'd1000, 32'd10);
    check("b2b busy at accept", 32'(busy), 32'd1);
    check("b2b previous result held", quotient, 32'd14);
    wait_done(0, 32'd0, 32'd0, lat, bcnt);
    check("b2b quotient", quotient, 32'd100);
    check("b2b remainder", remainder, 32'd0);
    check("b2b latency", 32'(lat), 32'd33);

    // Reset in the middle of an operation aborts it without a done pulse.
    issue(1'b0, 32'd12345, 32'd3);
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort quotient", quotient, 32'd0);
    check("abort remainder", remainder, 32'd0);
    check("abort div_by_zero", 32'(div_by_zero), 32'd0);
    done_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      done_seen |= done;
    end
    rst = 1'b1;
    repeat (40) begin
      @(negedge clk);
      done_seen |= done;
    end
    check("abort no done pulse", 32'(done_seen), 32'd0);
    rv = '{1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0};
    run_vec(rv, "post reset", 1'b1);

    for (int i = 0; i < 30; i++) begin
      int sel;
      rv.s = 1'($urandom_range(0, 1));
      rv.a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      sel  = $urandom_range(0, 7);
      case (sel)
        0:       rv.b = 32'd0;
        1:       rv.b = 32'($urandom_range(1, 15));
        2:       rv.b = 32'hFFFF_FFFF;
        default: rv.b = $urandom;
      endcase
      model(rv.s, rv.a, rv.b, rv.q, rv.r, rv.dz);
      run_vec(rv, $sformatf("rand%0d", i), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The module SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous reset, active-low; 0 resets all state immediately.
REQ-004 start  input  1  request a divide; sampled on the rising edge only when busy=0.
REQ-005 is_signed  input  1  1 = DIV (two's complement); 0 = DIVU; sampled with start.
REQ-006 dividend  input  32  register-file rdata1 operand (rs); sampled with start.
REQ-007 divisor  input  32  register-file rdata2 operand (rt); sampled with start.
REQ-008 busy  output  1  high from the accepting edge until the result edge.
REQ-009 done  output  1  one-cycle pulse; quotient and remainder are valid and new.
REQ-010 quotient  output  32  LO result; holds its value until the next done.
REQ-011 remainder  output  32  HI result; holds its value until the next done.
REQ-012 div_by_zero  output  1  qualifies the current result; holds its value with it.

Function
REQ-013 The block SHALL implement a restoring divider, one bit per cycle, on 32-bit magnitudes with a 33-bit partial remainder.
REQ-014 The FSM SHALL have the states IDLE, RUN and DONE.
- IDLE->RUN on start.
- RUN->DONE after 32 iterations.
- DONE->IDLE unconditionally, unless start is set, in which case DONE->RUN.
REQ-015 At the accepting edge N the block SHALL latch operand magnitudes, signs, the is_signed bit and the divisor==0 flag, and SHALL clear the 6-bit iteration counter.
REQ-016 Iterations SHALL occur on edges N+1..N+32.
REQ-017 At edge N+33 the block SHALL register sign-corrected results and assert done for that one cycle.
REQ-018 busy SHALL be 1 after edge N and through edge N+32, and SHALL be 0 from edge N+33.
REQ-019 start SHALL be ignored while busy=1; operand input changes during RUN SHALL have no effect.
REQ-020 start asserted during the done cycle SHALL be accepted, giving back-to-back operations with no idle cycle.
REQ-021 For signed operations, the quotient SHALL truncate toward zero and the remainder SHALL take the sign of the dividend (MIPS semantics).
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000, remainder 0 and div_by_zero=0.
REQ-023 For divisor 0 (either mode), latency SHALL be unchanged and outputs SHALL be quotient=0xFFFFFFFF, remainder=original dividend, div_by_zero=1.
REQ-024 For unsigned operations, no sign correction SHALL be applied; operands are full 32-bit magnitudes.
REQ-025 Between done pulses, quotient, remainder and div_by_zero SHALL remain stable.

Reset
REQ-026 rst=0 SHALL force the state to IDLE, the counter to 0 and all internal operand registers to 0, regardless of the current state.
REQ-027 Under reset, outputs SHALL be: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
REQ-028 Reset mid-RUN SHALL abort the operation with no done pulse.
REQ-029 The first start after reset release SHALL behave per REQ-015.

Structure
REQ-030 A shared package SHALL hold:
- the FSM state enum (IDLE/RUN/DONE);
- DIV_W=32;
- DIV_CNT_W=6;
- DIV_ITER=32;
- the constant DIV_ZERO_Q=0xFFFFFFFF.
REQ-031 One combinational sub-module, div_step, SHALL perform a single iteration: shift, trial subtract, restore, and produce the quotient bit.
REQ-032 Sign pre-negation, post-correction and the FSM SHALL reside in div_unit; the expected size is 150-250 lines.

Verification
REQ-033 The bench SHALL cover unsigned 100/7 with start at edge N: done at edge N+33, quotient=14, remainder=2, div_by_zero=0, busy high for 33 cycles.
REQ-034 The bench SHALL cover signed -7/2 (0xFFFFFFF9/0x00000002): quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; and signed 7/-2: quotient=0xFFFFFFFD, remainder=1.
REQ-035 The bench SHALL cover signed 0x80000000/0xFFFFFFFF: quotient=0x80000000, remainder=0; and unsigned 0xFFFFFFFF/1: quotient=0xFFFFFFFF, remainder=0.
REQ-036 The bench SHALL cover signed 0xFFFFFFFB/0: quotient=0xFFFFFFFF, remainder=0xFFFFFFFB, div_by_zero=1, same 33-cycle latency.
REQ-037 The bench SHALL cover start with new operands at cycle N+10 during RUN: the start is ignored and the original result is returned; then start during the done cycle yields the next result exactly 33 cycles later.
REQ-038 The bench SHALL cover rst=0 at iteration 10: outputs zero immediately, no done pulse; after release, 1000/10 yields quotient=100, remainder=0.
